// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-entry output register with stall, redirect and halt.
// Optional macro IFETCH_FAULT_EN adds a sticky fetch_fault output for PCs beyond the 32-word ROM.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'h0000007f
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef IFETCH_FAULT_EN
  output logic        fetch_fault,
`endif
  output logic        halted
);

  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_halted;
  logic        w_load;
  logic        w_take;
  logic        w_fault;

  assign w_load = (!r_out_valid || out_ready) && !r_halted && !redirect_valid;

`ifdef IFETCH_FAULT_EN
  logic r_fault;
  // A PC outside the ROM window faults instead of fetching a wrapped word.
  assign w_fault     = w_load && (r_pc[31:7] != 25'd0);
  assign fetch_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign w_take = w_load && !w_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'd0;
      r_out_pc    <= 32'd0;
      r_halted    <= 1'b0;
`ifdef IFETCH_FAULT_EN
      r_fault     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      r_pc        <= {redirect_pc[31:2], 2'b00};
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
`ifdef IFETCH_FAULT_EN
      r_fault     <= 1'b0;
`endif
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_instr <= rom_q;
      r_out_pc    <= r_pc;
      // The halt word is still presented; the PC parks on it.
      if (rom_q == HALT_WORD) begin
        r_halted <= 1'b1;
      end else begin
        r_pc <= r_pc + 32'd4;
      end
    end else if (w_fault) begin
      r_out_valid <= 1'b0;
      r_halted    <= 1'b1;
`ifdef IFETCH_FAULT_EN
      r_fault     <= 1'b1;
`endif
    end else if (out_ready && r_halted) begin
      r_out_valid <= 1'b0;
    end
  end

  assign rom_addr  = r_pc[6:2];
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, a reset-latency sequence,
// then randomized traffic against a rule-level reference model.
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'h0000007f;
`ifdef IFETCH_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_q;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault_w;

  logic [31:0] rom [32];
  assign rom_q = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
`ifdef IFETCH_FAULT_EN
    .fetch_fault    (fault_w),
`endif
    .halted         (halted)
  );
`ifndef IFETCH_FAULT_EN
  assign fault_w = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halt;
    logic        chk_addr;
    logic [4:0]  e_addr;
    logic        e_fault;
  } vec_t;

  vec_t tv [22];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic h, input logic ca, input logic [4:0] a, input logic f);
    vec_t x;
    x.rst = r; x.rv = rv; x.rpc = rpc; x.rdy = rdy;
    x.e_valid = v; x.e_pc = pc; x.e_instr = ins; x.e_halt = h;
    x.chk_addr = ca; x.e_addr = a; x.e_fault = f;
    return x;
  endfunction

  // Reference model state: architectural view, advanced once per clock from the current inputs.
  logic [31:0] m_pc, m_instr, m_opc;
  logic        m_valid, m_halt, m_fault;

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] word;
    if (r) begin
      m_pc = 32'd0; m_valid = 0; m_instr = 0; m_opc = 0; m_halt = 0; m_fault = 0;
    end else if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC; m_valid = 0; m_halt = 0; m_fault = 0;
    end else if ((!m_valid || rdy) && !m_halt) begin
      word = rom[(m_pc / 4) % 32];
      if (FAULT_EN && m_pc >= 32'd128) begin
        m_fault = 1; m_halt = 1; m_valid = 0;
      end else begin
        m_valid = 1; m_instr = word; m_opc = m_pc;
        if (word == HALT) m_halt = 1;
        else m_pc = m_pc + 32'd4;
      end
    end else if (rdy && m_halt) begin
      m_valid = 0;
    end
  endtask

  int cycles;

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h00000013 + (i << 7);
    rom[0]  = 32'h00500293;
    rom[1]  = 32'h00500293;
    rom[2]  = 32'h00c000ef;
    rom[6]  = HALT;

    tv[0]  = mk(1,0,0,1,         0,0,0,0,1,0,0);
    tv[1]  = mk(0,0,0,1,         1,0,rom[0],0,1,1,0);
    tv[2]  = mk(0,0,0,1,         1,4,rom[1],0,1,2,0);
    tv[3]  = mk(0,0,0,0,         1,4,rom[1],0,1,2,0);
    tv[4]  = mk(0,0,0,0,         1,4,rom[1],0,1,2,0);
    tv[5]  = mk(0,0,0,0,         1,4,rom[1],0,1,2,0);
    tv[6]  = mk(0,0,0,1,         1,8,rom[2],0,1,3,0);
    tv[7]  = mk(0,1,32'h15,0,    0,8,rom[2],0,1,5,0);
    tv[8]  = mk(0,0,0,1,         1,32'h14,rom[5],0,1,6,0);
    tv[9]  = mk(0,0,0,1,         1,32'h18,HALT,1,0,0,0);
    tv[10] = mk(0,0,0,1,         0,32'h18,HALT,1,0,0,0);
    tv[11] = mk(0,0,0,1,         0,32'h18,HALT,1,0,0,0);
    tv[12] = mk(0,1,32'h28,1,    0,32'h18,HALT,0,1,10,0);
    tv[13] = mk(0,0,0,1,         1,32'h28,rom[10],0,1,11,0);
    tv[14] = mk(0,0,0,0,         1,32'h28,rom[10],0,1,11,0);
    tv[15] = mk(0,1,32'h18,1,    0,32'h28,rom[10],0,1,6,0);
    tv[16] = mk(0,0,0,0,         1,32'h18,HALT,1,0,0,0);
    tv[17] = mk(0,0,0,0,         1,32'h18,HALT,1,0,0,0);
    tv[18] = mk(1,0,0,0,         0,0,0,0,1,0,0);
    tv[19] = mk(0,1,32'h7C,1,    0,0,0,0,1,31,0);
    tv[20] = mk(0,0,0,1,         1,32'h7C,rom[31],0,1,0,0);
    if (FAULT_EN) tv[21] = mk(0,0,0,1, 0,32'h7C,rom[31],1,0,0,1);
    else          tv[21] = mk(0,0,0,1, 1,32'h80,rom[0],0,1,1,0);

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      rst = tv[i].rst; redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc; out_ready = tv[i].rdy;
      @(posedge clk); #1;
      chk("vec_valid", i, {31'd0, out_valid}, {31'd0, tv[i].e_valid});
      chk("vec_pc", i, out_pc, tv[i].e_pc);
      chk("vec_instr", i, out_instr, tv[i].e_instr);
      chk("vec_halted", i, {31'd0, halted}, {31'd0, tv[i].e_halt});
      chk("vec_fault", i, {31'd0, fault_w}, {31'd0, tv[i].e_fault});
      if (tv[i].chk_addr) chk("vec_rom_addr", i, {27'd0, rom_addr}, {27'd0, tv[i].e_addr});
      $display("vec %0d: rst=%0b rv=%0b rpc=%08h rdy=%0b -> valid=%0b pc=%08h instr=%08h halted=%0b addr=%0d",
               i, tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy, out_valid, out_pc, out_instr, halted, rom_addr);
    end

    // First word must appear exactly one cycle after reset is released.
    rst = 1; redirect_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    cycles = 0;
    while (!out_valid && cycles < 6) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("first_load_latency", 0, cycles, 1);
    chk("first_load_pc", 0, out_pc, 32'd0);
    $display("reset release: first out_valid after %0d cycle(s)", cycles);

    // Randomized traffic against the model.
    for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
    for (int c = 0; c < 600; c++) begin
      logic r, rv, rdy;
      logic [31:0] rpc;
      r   = (c == 0) || ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFF);
      rdy = ($urandom_range(0, 9) < 7);
      rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
      model_step(r, rv, rpc, rdy);
      @(posedge clk); #1;
      chk("rnd_valid", c, {31'd0, out_valid}, {31'd0, m_valid});
      chk("rnd_pc", c, out_pc, m_opc);
      chk("rnd_instr", c, out_instr, m_instr);
      chk("rnd_halted", c, {31'd0, halted}, {31'd0, m_halt});
      chk("rnd_fault", c, {31'd0, fault_w}, {31'd0, m_fault});
      if (!m_halt) chk("rnd_rom_addr", c, {27'd0, rom_addr}, {27'd0, m_pc[6:2]});
      $display("rnd %0d: rst=%0b rv=%0b rpc=%08h rdy=%0b -> valid=%0b pc=%08h halted=%0b",
               c, r, rv, rpc, rdy, out_valid, out_pc, halted);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
